imm_assembler: RTL and testbench

Sequencing controller for the immediate-extension datapath. Accepts a stream of 8-bit immediate chunks from the decoder under a valid/ready handshake. Sign- or zero-extends the first chunk to 24 bits and shifts in up to two further chunks, so prefix-style instruction sequences can build full-width 24-bit immediates. It presents the assembled operand to the execute stage with a registered valid/ready output.

---
 rtl/imm_assembler_if.sv | 27 ++
 rtl/imm_assembler.sv | 105 ++++++++++
 tb/tb_imm_assembler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/imm_assembler_if.sv
// Chunk-in / operand-out handshake bundle for the immediate assembler.
// The master side feeds chunks and consumes operands; the slave side is
// the assembler itself.
interface imm_assembler_if;
  // Chunk stream from the decoder
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_imm;
  logic        in_last;
  logic        in_zext;
  // Assembled operand to the execute stage
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_imm;
  logic [1:0]  out_chunks;
  logic        out_err;

  modport master (
    output in_valid, in_imm, in_last, in_zext, out_ready,
    input  in_ready, out_valid, out_imm, out_chunks, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_last, in_zext, out_ready,
    output in_ready, out_valid, out_imm, out_chunks, out_err
  );
endinterface

// File: rtl/imm_assembler.sv
// Immediate assembler: collects one to three 8-bit chunks, sign- or
// zero-extends the first one, shifts the rest in and presents a 24-bit
// operand with a registered valid/ready handshake.
module imm_assembler (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  imm_assembler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [23:0] acc;
  logic [1:0]  cnt;
  logic        err_q;
  logic        valid_q;
  logic        ready_q;

  logic        accept;
  logic [23:0] first_ext;

  // A chunk moves only when the registered ready meets the upstream valid.
  assign accept    = bus.in_valid && ready_q;
  assign first_ext = bus.in_zext ? {16'h0000, bus.in_imm}
                                 : {{16{bus.in_imm[7]}}, bus.in_imm};

  // Sequencer: state, accumulator, chunk count and all registered outputs.
  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else if (flush) begin
      // Drop anything partial or held; the accumulator value is left as is.
      state   <= IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            acc   <= first_ext;
            cnt   <= 2'd1;
            err_q <= 1'b0;
            if (bus.in_last) begin
              state   <= HOLD;
              valid_q <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (accept) begin
            acc <= {acc[15:0], bus.in_imm};
            cnt <= cnt + 2'd1;
            // Third chunk closes the operand whether or not it was marked last.
            if (bus.in_last || cnt == 2'd2) begin
              state   <= HOLD;
              valid_q <= 1'b1;
              ready_q <= 1'b0;
              err_q   <= !bus.in_last;
            end
          end
        end

        HOLD: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_imm    = acc;
  assign bus.out_chunks = cnt;
  assign bus.out_err    = err_q;

endmodule

// File: tb/tb_imm_assembler.sv
// Bench for imm_assembler: a table of chunk sequences with hand-computed
// operands, a scoreboard queue checked at the output handshake, and
// hand-written backpressure, flush and reset-in-HOLD sequences.
module tb_imm_assembler;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  imm_assembler_if bus ();

  imm_assembler dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] imm;
    logic [1:0]  chunks;
    logic        err;
  } exp_t;

  typedef struct {
    int              n;
    logic [2:0][7:0] c;     // c[0] is sent first
    logic            zext;
    logic            last;  // in_last on the final chunk
    logic [23:0]     e_imm;
    logic [1:0]      e_cnt;
    logic            e_err;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic z, input logic l,
                              input logic [23:0] ei, input logic [1:0] ec, input logic ee);
    vec_t v;
    v.n = n; v.c[0] = c0; v.c[1] = c1; v.c[2] = c2;
    v.zext = z; v.last = l; v.e_imm = ei; v.e_cnt = ec; v.e_err = ee;
    return v;
  endfunction

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  logic        held_v = 1'b0;
  logic [23:0] held_imm;
  logic [1:0]  held_cnt;
  logic        held_err;

  always @(negedge clk) begin
    if (held_v && bus.out_valid) begin
      check("hold_imm_stable", 32'(bus.out_imm), 32'(held_imm));
      check("hold_chunks_stable", 32'(bus.out_chunks), 32'(held_cnt));
      check("hold_err_stable", 32'(bus.out_err), 32'(held_err));
    end
    if (bus.out_valid && bus.out_ready && !rst && !flush) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(bus.out_valid), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_imm", 32'(bus.out_imm), 32'(e.imm));
        check("out_chunks", 32'(bus.out_chunks), 32'(e.chunks));
        check("out_err", 32'(bus.out_err), 32'(e.err));
      end
    end
    held_v   = bus.out_valid && !bus.out_ready && !rst && !flush;
    held_imm = bus.out_imm;
    held_cnt = bus.out_chunks;
    held_err = bus.out_err;
  end

  // Present one chunk from posedge+1 until accepted; returns at posedge+1.
  task automatic send(input logic [7:0] d, input logic l, input logic z);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_imm   = d;
    bus.in_last  = l;
    bus.in_zext  = z;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout_in_ready", 32'(bus.in_ready), 32'(1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  vec_t vecs[10];

  initial begin
    vecs[0] = mk(1, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 24'hFFFF80, 2'd1, 1'b0);
    vecs[1] = mk(1, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 24'h000080, 2'd1, 1'b0);
    vecs[2] = mk(2, 8'hF1, 8'h23, 8'h00, 1'b0, 1'b1, 24'hFFF123, 2'd2, 1'b0);
    vecs[3] = mk(2, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 24'h001234, 2'd2, 1'b0);
    vecs[4] = mk(3, 8'hAB, 8'hCD, 8'hEF, 1'b0, 1'b1, 24'hABCDEF, 2'd3, 1'b0);
    vecs[5] = mk(3, 8'hAB, 8'hCD, 8'hEF, 1'b0, 1'b0, 24'hABCDEF, 2'd3, 1'b1);
    vecs[6] = mk(1, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1, 24'h00005A, 2'd1, 1'b0);
    vecs[7] = mk(2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 24'h00FF01, 2'd2, 1'b0);
    vecs[8] = mk(2, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 24'hFF8000, 2'd2, 1'b0);
    vecs[9] = mk(3, 8'h7F, 8'h80, 8'h01, 1'b1, 1'b1, 24'h7F8001, 2'd3, 1'b0);

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_last = 1'b0; bus.in_zext = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(0));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_imm", 32'(bus.out_imm), 32'(0));
    check("rst_out_chunks", 32'(bus.out_chunks), 32'(0));
    check("rst_out_err", 32'(bus.out_err), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven sequences, chunks streamed back-to-back
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.imm = vecs[i].e_imm; e.chunks = vecs[i].e_cnt; e.err = vecs[i].e_err;
      sb.push_back(e);
      for (int j = 0; j < vecs[i].n; j++) begin
        // Later chunks carry the opposite zext to show it is ignored.
        send(vecs[i].c[j], (j == vecs[i].n - 1) ? vecs[i].last : 1'b0,
             (j == 0) ? vecs[i].zext : ~vecs[i].zext);
      end
      @(negedge clk);
      check($sformatf("v%0d_latency_out_valid", i), 32'(bus.out_valid), 32'(1));
      @(posedge clk);
      #1;
    end
    wait_drain();

    // Backpressure with a chunk waiting on the input
    bus.out_ready = 1'b0;
    sb.push_back('{imm: 24'h000042, chunks: 2'd1, err: 1'b0});
    send(8'h42, 1'b1, 1'b1);
    sb.push_back('{imm: 24'h000055, chunks: 2'd1, err: 1'b0});
    bus.in_valid = 1'b1; bus.in_imm = 8'h55; bus.in_last = 1'b1; bus.in_zext = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'(0));
      check("bp_out_valid", 32'(bus.out_valid), 32'(1));
      check("bp_out_imm", 32'(bus.out_imm), 32'h000042);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_after_hs_in_ready", 32'(bus.in_ready), 32'(1));
    check("bp_after_hs_out_valid", 32'(bus.out_valid), 32'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    check("bp_next_chunk_out_valid", 32'(bus.out_valid), 32'(1));
    wait_drain();

    // Flush after the first chunk of a two-chunk sequence
    send(8'h12, 1'b0, 1'b0);
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_imm = 8'h34; bus.in_last = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("flush_out_valid", 32'(bus.out_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    sb.push_back('{imm: 24'h000007, chunks: 2'd1, err: 1'b0});
    send(8'h07, 1'b1, 1'b1);
    wait_drain();

    // Reset while HOLD is presented with out_ready high
    bus.out_ready = 1'b0;
    send(8'h99, 1'b1, 1'b0);
    @(negedge clk);
    check("rsthold_pre_out_valid", 32'(bus.out_valid), 32'(1));
    check("rsthold_pre_out_imm", 32'(bus.out_imm), 32'hFFFF99);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rsthold_out_valid", 32'(bus.out_valid), 32'(0));
    check("rsthold_out_imm", 32'(bus.out_imm), 32'(0));
    check("rsthold_out_chunks", 32'(bus.out_chunks), 32'(0));
    check("rsthold_in_ready", 32'(bus.in_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.push_back('{imm: 24'hFFFFC3, chunks: 2'd1, err: 1'b0});
    send(8'hC3, 1'b1, 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
